// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline forwarding/hazard controller.
package forward_hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/forward_hazard_ctrl_fwd_select.sv
// Resolves one EX operand source against the in-flight EX and MEM slots.
module forward_hazard_ctrl_fwd_select
  import forward_hazard_ctrl_pkg::*;
#(
  parameter bit ZERO_HW = 1'b1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  slot_t             ex,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        sel
);

  logic zero_src;
  logic ex_hit;
  logic mem_hit;

  // A load in EX has no ALU result to forward; the load-use stall covers it.
  assign zero_src = ZERO_HW && (rs == '0);
  assign ex_hit   = ex.valid && ex.reg_write && !ex.mem_read && (ex.rd == rs);
  assign mem_hit  = mem_valid && mem_reg_write && (mem_rd == rs);

  always_comb begin
    sel = FWD_REG;
    if (use_rs && !zero_src) begin
      if (ex_hit) begin
        sel = FWD_ALU;
      end else if (mem_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding select generation, load-use stall FSM and stall counter for the
// 5-stage pipeline; sits beside ID/EX.
module forward_hazard_ctrl
  import forward_hazard_ctrl_pkg::*;
#(
  parameter bit          ZERO_HW = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_count
);

  // The WB slot is the MEM slot one edge later; selects are computed from
  // pre-edge state, so MEM already stands in for WB and no WB copy is kept.
  slot_t             ex_q;
  slot_t             id_slot;
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_rw_q;
  state_t            state_q;
  state_t            state_d;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              load_use;
  logic              stall;
  logic              bubble;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_q.rd) && !(ZERO_HW && (id_rs1 == '0));
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_q.rd) && !(ZERO_HW && (id_rs2 == '0));
  assign load_use = id_valid && ex_q.valid && ex_q.mem_read && (rs1_hit || rs2_hit);
  assign bubble   = !id_valid || flush || stall;

  assign id_slot.valid     = !bubble;
  assign id_slot.rd        = id_rd;
  assign id_slot.reg_write = id_reg_write;
  assign id_slot.mem_read  = id_mem_read;

  forward_hazard_ctrl_fwd_select #(.ZERO_HW(ZERO_HW)) u_fwd_select_a (
    .rs            (id_rs1),
    .use_rs        (id_use_rs1),
    .ex            (ex_q),
    .mem_valid     (mem_valid_q),
    .mem_rd        (mem_rd_q),
    .mem_reg_write (mem_rw_q),
    .sel           (sel_a)
  );

  forward_hazard_ctrl_fwd_select #(.ZERO_HW(ZERO_HW)) u_fwd_select_b (
    .rs            (id_rs2),
    .use_rs        (id_use_rs2),
    .ex            (ex_q),
    .mem_valid     (mem_valid_q),
    .mem_rd        (mem_rd_q),
    .mem_reg_write (mem_rw_q),
    .sel           (sel_b)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority: hold freezes everything, then flush suppresses the stall.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    if (hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use && !flush) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_d    = STALL;
          end
        end
        STALL:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      forwardA    <= FWD_REG;
      forwardB    <= FWD_REG;
      stall_count <= '0;
    end else if (!hold) begin
      ex_q        <= id_slot;
      mem_valid_q <= ex_q.valid;
      mem_rd_q    <= ex_q.rd;
      mem_rw_q    <= ex_q.reg_write;
      forwardA    <= bubble ? FWD_REG : sel_a;
      forwardB    <= bubble ? FWD_REG : sel_b;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Scoreboard bench for forward_hazard_ctrl: a reference pipeline model queues
// expected selects/counter per cycle, compared one edge later.
module tb_forward_hazard_ctrl;

  localparam int unsigned TB_CNT_W = 4;

  typedef struct packed {
    logic [1:0]          fa;
    logic [1:0]          fb;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset;
  logic                id_valid;
  logic [3:0]          id_rs1;
  logic [3:0]          id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [3:0]          id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                flush;
  logic                hold;
  logic [1:0]          forwardA;
  logic [1:0]          forwardB;
  logic                pc_write;
  logic                ifid_write;
  logic [TB_CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // reference model state
  logic                m_ex_v, m_ex_rw, m_ex_mr, m_mem_v, m_mem_rw, m_st;
  logic [3:0]          m_ex_rd, m_mem_rd;
  logic [1:0]          m_fa, m_fb;
  logic [TB_CNT_W-1:0] m_cnt;
  logic                last_pcw;

  forward_hazard_ctrl #(.ZERO_HW(1'b1), .CNT_W(TB_CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .hold         (hold),
    .forwardA     (forwardA),
    .forwardB     (forwardB),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ex_v = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_rd = 0;
    m_mem_v = 0; m_mem_rw = 0; m_mem_rd = 0;
    m_st = 0; m_fa = 2'b00; m_fb = 2'b00; m_cnt = '0;
    last_pcw = 1'b1;
  endtask

  function automatic logic [1:0] fsel(input logic [3:0] rs, input logic u);
    if (!u || rs == 4'd0) return 2'b00;
    if (m_ex_v && m_ex_rw && !m_ex_mr && m_ex_rd == rs) return 2'b10;
    if (m_mem_v && m_mem_rw && m_mem_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Called just after a rising edge: drive, check combinational outputs,
  // advance the model, then compare registered outputs after the next edge.
  task automatic step(input logic v, input logic [3:0] r1, input logic u1,
                      input logic [3:0] r2, input logic u2, input logic [3:0] rd,
                      input logic rw, input logic mr, input logic fl, input logic hd);
    logic lu, stall, bub;
    logic [1:0] nfa, nfb;
    exp_t e;
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl; hold = hd;
    #1;
    lu = v && m_ex_v && m_ex_mr &&
         ((u1 && r1 != 4'd0 && r1 == m_ex_rd) || (u2 && r2 != 4'd0 && r2 == m_ex_rd));
    stall = !hd && !fl && !m_st && lu;
    check_eq("pc_write", 32'(pc_write), 32'(!(hd || stall)));
    check_eq("ifid_write", 32'(ifid_write), 32'(!(hd || stall)));
    last_pcw = !(hd || stall);
    if (!hd) begin
      bub = !v || fl || stall;
      nfa = bub ? 2'b00 : fsel(r1, u1);
      nfb = bub ? 2'b00 : fsel(r2, u2);
      m_mem_v = m_ex_v; m_mem_rd = m_ex_rd; m_mem_rw = m_ex_rw;
      m_ex_v = !bub; m_ex_rd = rd; m_ex_rw = rw; m_ex_mr = mr;
      m_fa = nfa; m_fb = nfb;
      if (stall && m_cnt != {TB_CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_st = stall;
    end
    exp_q.push_back('{fa: m_fa, fb: m_fb, cnt: m_cnt});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_eq("forwardA", 32'(forwardA), 32'(e.fa));
    check_eq("forwardB", 32'(forwardB), 32'(e.fb));
    check_eq("stall_count", 32'(stall_count), 32'(e.cnt));
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2,
                     input logic fl = 1'b0);
    step(1, r1, 1, r2, 1, rd, 1, 0, fl, 0);
  endtask

  task automatic load(input logic [3:0] rd, input logic [3:0] base);
    step(1, base, 1, 4'd0, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic nop();
    step(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] r1, r2, rd;
    logic v, u1, u2, rw, mr;
    reset = 1'b1;
    step_idle();
    model_reset();
    #2;
    check_eq("rst_forwardA", 32'(forwardA), 32'd0);
    check_eq("rst_forwardB", 32'(forwardB), 32'd0);
    check_eq("rst_pc_write", 32'(pc_write), 32'd1);
    check_eq("rst_ifid_write", 32'(ifid_write), 32'd1);
    check_eq("rst_stall_count", 32'(stall_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // ALU back-to-back forwarding
    alu(4'd1, 4'd2, 4'd3);
    alu(4'd2, 4'd1, 4'd3);
    check_eq("ex_fwd_a", 32'(forwardA), 32'b10);
    // MEM forwarding and EX-over-MEM priority
    alu(4'd1, 4'd2, 4'd3);
    nop();
    alu(4'd4, 4'd5, 4'd1);
    check_eq("mem_fwd_b", 32'(forwardB), 32'b01);
    alu(4'd1, 4'd2, 4'd3);
    alu(4'd1, 4'd5, 4'd6);
    alu(4'd4, 4'd5, 4'd1);
    check_eq("prio_fwd_b", 32'(forwardB), 32'b10);

    // load-use: one stall, then both operands from WB
    load(4'd1, 4'd2);
    alu(4'd2, 4'd1, 4'd1);
    check_eq("lu_bubble_a", 32'(forwardA), 32'b00);
    check_eq("lu_count", 32'(stall_count), 32'd1);
    alu(4'd2, 4'd1, 4'd1);
    check_eq("lu_wb_a", 32'(forwardA), 32'b01);
    check_eq("lu_wb_b", 32'(forwardB), 32'b01);

    // flush beats stall; r0 never forwarded
    load(4'd1, 4'd2);
    alu(4'd2, 4'd1, 4'd1, 1'b1);
    check_eq("flush_count", 32'(stall_count), 32'd1);
    alu(4'd0, 4'd3, 4'd3);
    alu(4'd5, 4'd0, 4'd0);
    check_eq("r0_fwd_a", 32'(forwardA), 32'b00);
    load(4'd0, 4'd3);
    alu(4'd5, 4'd0, 4'd0);

    // hold for 3 cycles while in STALL
    load(4'd6, 4'd2);
    alu(4'd7, 4'd6, 4'd6);
    repeat (3) step(1, 4'd6, 1, 4'd6, 1, 4'd7, 1, 0, 0, 1);
    alu(4'd7, 4'd6, 4'd6);
    check_eq("hold_resume_a", 32'(forwardA), 32'b01);

    // async reset in STALL
    load(4'd3, 4'd2);
    alu(4'd4, 4'd3, 4'd0);
    #3;
    reset = 1'b1;
    step_idle();
    #1;
    check_eq("mid_rst_forwardA", 32'(forwardA), 32'd0);
    check_eq("mid_rst_forwardB", 32'(forwardB), 32'd0);
    check_eq("mid_rst_pc_write", 32'(pc_write), 32'd1);
    check_eq("mid_rst_ifid_write", 32'(ifid_write), 32'd1);
    check_eq("mid_rst_stall_count", 32'(stall_count), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // counter saturation
    for (int i = 0; i < 18; i++) begin
      load(4'd1, 4'd2);
      alu(4'd2, 4'd1, 4'd3);
      alu(4'd2, 4'd1, 4'd3);
    end
    check_eq("sat_count", 32'(stall_count), 32'({TB_CNT_W{1'b1}}));

    // random traffic; ID contents held whenever IF/ID was held
    v = 0; r1 = 0; r2 = 0; rd = 0; u1 = 0; u2 = 0; rw = 0; mr = 0;
    for (int i = 0; i < 400; i++) begin
      if (last_pcw) begin
        v  = ($urandom_range(0, 7) != 0);
        r1 = 4'($urandom_range(0, 3));
        r2 = 4'($urandom_range(0, 3));
        rd = 4'($urandom_range(0, 3));
        u1 = 1'($urandom_range(0, 1));
        u2 = 1'($urandom_range(0, 1));
        rw = ($urandom_range(0, 3) != 0);
        mr = ($urandom_range(0, 2) == 0);
      end
      step(v, r1, u1, r2, u2, rd, rw, mr,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic step_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0; hold = 0;
  endtask

endmodule
